// File: rtl/ikbd_sci_if.sv
// Parallel-side handshake bundle of the IKBD serial interface: TX holding-register
// offer/accept plus RX data, valid/ack and error flags.
interface ikbd_sci_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       rx_overrun;
    logic       rx_frame_err;

    modport master (
        output tx_data, tx_valid, rx_ack,
        input  tx_ready, tx_busy, rx_data, rx_valid, rx_overrun, rx_frame_err
    );

    modport slave (
        input  tx_data, tx_valid, rx_ack,
        output tx_ready, tx_busy, rx_data, rx_valid, rx_overrun, rx_frame_err
    );
endinterface

// File: rtl/ikbd_sci.sv
// Full-duplex 8N1 serial link to the keyboard ACIA: 16x oversampled receiver with
// overrun/framing flags, transmitter with a one-byte holding register in front of the shifter.
module ikbd_sci #(
    parameter int BIT_CLKS = 1024
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ser_in,
    output logic       ser_out,
    ikbd_sci_if.slave  bus
);
    localparam int TICK_DIV = BIT_CLKS / 16;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam int BW = $clog2(BIT_CLKS);
    localparam logic [BW-1:0] BIT_LAST = BW'(BIT_CLKS - 1);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    logic          sync1_q, sync2_q;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick_s;

    rx_state_e     rx_state_q, rx_state_d;
    logic [3:0]    rx_sub_q, rx_sub_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_armed_q, rx_armed_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          rx_ovr_q, rx_ovr_d;
    logic          rx_ferr_q, rx_ferr_d;
    logic          ack_s;

    tx_state_e     tx_state_q, tx_state_d;
    logic [BW-1:0] tx_timer_q, tx_timer_d;
    logic [2:0]    tx_idx_q, tx_idx_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic [7:0]    tx_hold_q, tx_hold_d;
    logic          tx_ready_q, tx_ready_d;
    logic          tx_busy_q, tx_busy_d;
    logic          ser_q, ser_d;
    logic          accept_s, timer_end_s;

    assign tick_s      = (tick_cnt_q == TICK_LAST);
    assign tick_cnt_d  = tick_s ? {TW{1'b0}} : (tick_cnt_q + TW'(1));
    assign ack_s       = bus.rx_ack && rx_valid_q;
    assign accept_s    = bus.tx_valid && tx_ready_q;
    assign timer_end_s = (tx_timer_q == BIT_LAST);

    // Line synchronizer and free-running oversample tick divider
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            tick_cnt_q <= {TW{1'b0}};
        end else begin
            sync1_q    <= ser_in;
            sync2_q    <= sync1_q;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // Receiver next-state: the armed flag blocks a held-low break from retriggering
    always_comb begin
        rx_state_d = rx_state_q;
        rx_sub_d   = rx_sub_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_armed_d = rx_armed_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        rx_ovr_d   = rx_ovr_q;
        rx_ferr_d  = rx_ferr_q;
        if (ack_s) begin
            rx_valid_d = 1'b0;
            rx_ovr_d   = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end
        if (tick_s) begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (!sync2_q && rx_armed_q) begin
                        rx_state_d = RX_START;
                        rx_sub_d   = 4'd7;
                        rx_armed_d = 1'b0;
                    end else if (sync2_q) begin
                        rx_armed_d = 1'b1;
                    end else begin
                        rx_armed_d = rx_armed_q;
                    end
                end
                RX_START: begin
                    if (rx_sub_q == 4'd0) begin
                        if (!sync2_q) begin
                            rx_state_d = RX_DATA;
                            rx_sub_d   = 4'd15;
                            rx_bit_d   = 3'd0;
                        end else begin
                            rx_state_d = RX_IDLE;
                            rx_armed_d = 1'b1;
                        end
                    end else begin
                        rx_sub_d = rx_sub_q - 4'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_sub_q == 4'd0) begin
                        rx_shift_d = {sync2_q, rx_shift_q[7:1]};
                        rx_sub_d   = 4'd15;
                        rx_bit_d   = rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) begin
                            rx_state_d = RX_STOP;
                        end else begin
                            rx_state_d = RX_DATA;
                        end
                    end else begin
                        rx_sub_d = rx_sub_q - 4'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_sub_q == 4'd0) begin
                        rx_state_d = RX_IDLE;
                        rx_armed_d = sync2_q;
                        if (!sync2_q) begin
                            rx_ferr_d = 1'b1;
                        end else if (!rx_valid_q || ack_s) begin
                            rx_data_d  = rx_shift_q;
                            rx_valid_d = 1'b1;
                            rx_ferr_d  = 1'b0;
                        end else begin
                            rx_ovr_d = 1'b1;
                        end
                    end else begin
                        rx_sub_d = rx_sub_q - 4'd1;
                    end
                end
                default: rx_state_d = RX_IDLE;
            endcase
        end else begin
            rx_state_d = rx_state_q;
        end
    end

    // Receiver state and result registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state_q <= RX_IDLE;
            rx_sub_q   <= 4'd0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rx_armed_q <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_sub_q   <= rx_sub_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_armed_q <= rx_armed_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_ovr_q   <= rx_ovr_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    // Transmitter next-state: a full holding register at end of stop chains straight into a start bit
    always_comb begin
        tx_state_d = tx_state_q;
        tx_timer_d = tx_timer_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx_hold_d  = tx_hold_q;
        tx_ready_d = tx_ready_q;
        tx_busy_d  = tx_busy_q;
        ser_d      = ser_q;
        if (accept_s) begin
            tx_hold_d  = bus.tx_data;
            tx_ready_d = 1'b0;
        end else begin
            tx_hold_d = tx_hold_q;
        end
        case (tx_state_q)
            TX_IDLE: begin
                if (!tx_ready_q) begin
                    tx_shift_d = tx_hold_q;
                    tx_ready_d = 1'b1;
                    ser_d      = 1'b0;
                    tx_busy_d  = 1'b1;
                    tx_timer_d = {BW{1'b0}};
                    tx_state_d = TX_START;
                end else begin
                    tx_state_d = TX_IDLE;
                end
            end
            TX_START: begin
                if (timer_end_s) begin
                    tx_timer_d = {BW{1'b0}};
                    ser_d      = tx_shift_q[0];
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_idx_d   = 3'd0;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_timer_d = tx_timer_q + BW'(1);
                end
            end
            TX_DATA: begin
                if (timer_end_s) begin
                    tx_timer_d = {BW{1'b0}};
                    if (tx_idx_q == 3'd7) begin
                        ser_d      = 1'b1;
                        tx_state_d = TX_STOP;
                    end else begin
                        ser_d      = tx_shift_q[0];
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_idx_d   = tx_idx_q + 3'd1;
                    end
                end else begin
                    tx_timer_d = tx_timer_q + BW'(1);
                end
            end
            TX_STOP: begin
                if (timer_end_s) begin
                    tx_timer_d = {BW{1'b0}};
                    if (!tx_ready_q) begin
                        tx_shift_d = tx_hold_q;
                        tx_ready_d = 1'b1;
                        ser_d      = 1'b0;
                        tx_state_d = TX_START;
                    end else begin
                        ser_d      = 1'b1;
                        tx_busy_d  = 1'b0;
                        tx_state_d = TX_IDLE;
                    end
                end else begin
                    tx_timer_d = tx_timer_q + BW'(1);
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Transmitter state, holding register and line flop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_q <= TX_IDLE;
            tx_timer_q <= {BW{1'b0}};
            tx_idx_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            tx_hold_q  <= 8'h00;
            tx_ready_q <= 1'b1;
            tx_busy_q  <= 1'b0;
            ser_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_timer_q <= tx_timer_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            tx_hold_q  <= tx_hold_d;
            tx_ready_q <= tx_ready_d;
            tx_busy_q  <= tx_busy_d;
            ser_q      <= ser_d;
        end
    end

    assign ser_out          = ser_q;
    assign bus.tx_ready     = tx_ready_q;
    assign bus.tx_busy      = tx_busy_q;
    assign bus.rx_data      = rx_data_q;
    assign bus.rx_valid     = rx_valid_q;
    assign bus.rx_overrun   = rx_ovr_q;
    assign bus.rx_frame_err = rx_ferr_q;
endmodule

// File: doc/ikbd_sci.md
IKBD_SCI -- requirements
Module: ikbd_sci

Interface
REQ-001 Parameter BIT_CLKS, default 1024: clk cycles per serial bit (8 MHz / 1024 = 7812.5 bit/s); SHALL be a multiple of 16 and at least 32.
REQ-002 clk  input  1  system clock; all logic on posedge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 ser_in  input  1  serial line from ACIA TX; asynchronous; idle high.
REQ-005 ser_out  output  1  serial line to ACIA RX; idle high.
REQ-006 tx_data  input  8  byte to send.
REQ-007 tx_valid  input  1  tx_data offered.
REQ-008 tx_ready  output  1  holding register empty.
REQ-009 tx_busy  output  1  frame currently on ser_out.
REQ-010 rx_data  output  8  last received byte.
REQ-011 rx_valid  output  1  rx_data unread.
REQ-012 rx_ack  input  1  consumer has taken rx_data.
REQ-013 rx_overrun  output  1  byte lost because rx_valid was still set.
REQ-014 rx_frame_err  output  1  last frame had stop bit low.

Function
REQ-015 Frame format: 8N1, LSB first; 1 start bit (0), 8 data bits, 1 stop bit (1).
REQ-016 ser_in SHALL pass through a 2-flop synchronizer before any use; all RX timing is relative to the synchronized signal.
REQ-017 RX sample tick: free-running counter, one tick every BIT_CLKS/16 clocks; RX state advances only on ticks.
REQ-018 RX FSM states: IDLE, START, DATA, STOP.
REQ-019 IDLE -> START on the first tick that sees synchronized ser_in = 0; sub-bit counter loads 7.
REQ-020 START: at sub-bit count 0 (mid start bit) line = 0 -> DATA; line = 1 -> IDLE (glitch, nothing reported).
REQ-021 DATA: sample once per 16 ticks at mid bit and shift into the MSB; after 8 samples -> STOP.
REQ-022 STOP: sample at mid bit, then return to IDLE on the same tick.
REQ-023 Stop = 1 and rx_valid = 0: rx_data <= byte, rx_valid <= 1, rx_frame_err <= 0.
REQ-024 Stop = 1 and rx_valid = 1: byte discarded, rx_data unchanged, rx_overrun <= 1.
REQ-025 Stop = 0: byte discarded, rx_frame_err <= 1, rx_valid unchanged; in IDLE a new start is only accepted after the line has been seen high for at least one tick (break does not retrigger).
REQ-026 rx_ack = 1 clears rx_valid and rx_overrun on the next clock; rx_ack while rx_valid = 0 is ignored.
REQ-027 rx_ack on the same clock as a completed stop-bit sample: the new byte is stored, rx_valid stays 1, no overrun.
REQ-028 TX has a 1-byte holding register plus a shift register; tx_ready = holding register empty.
REQ-029 Transfer: tx_valid && tx_ready on a clock edge latches tx_data; tx_ready drops on the following cycle.
REQ-030 TX FSM states: IDLE, START, DATA, STOP; bit timer counts BIT_CLKS clocks per bit.
REQ-031 IDLE with holding full: next clock moves holding -> shift register, tx_ready <= 1, ser_out <= 0 (START), tx_busy <= 1.
REQ-032 Each bit SHALL be held exactly BIT_CLKS clocks; a frame lasts 10*BIT_CLKS clocks.
REQ-033 At the end of STOP with holding full: the next frame's start bit begins on the very next clock (no idle gap); otherwise -> IDLE, tx_busy <= 0, ser_out = 1.
REQ-034 A tx_valid while tx_ready = 0 SHALL be ignored; the offered byte is neither latched nor lost silently from the holding register.
REQ-035 ser_out SHALL be driven from a flop (glitch-free).
REQ-036 RX and TX SHALL be fully independent (full duplex; a loopback ser_out -> ser_in works).

Reset
REQ-037 reset_n low, asynchronously: both FSMs IDLE, all counters 0, holding empty; ser_out = 1, tx_ready = 1, tx_busy = 0, rx_valid = 0, rx_overrun = 0, rx_frame_err = 0, rx_data = 8'h00; synchronizer flops = 1.
REQ-038 Reset mid-frame aborts the frame; ser_out returns to 1 immediately; after release the receiver waits for a fresh falling edge.

Verification
REQ-039 BIT_CLKS=32, tx_data=8'hA5 pulsed on idle -> ser_out low for 32 clocks, then bits 1,0,1,0,0,1,0,1, then 1 for 32 clocks; tx_busy high for 320 clocks.
REQ-040 Two bytes 8'h01, 8'h80 offered back-to-back -> second start bit immediately follows first stop bit, frames 640 clocks total, tx_ready low only while holding is full.
REQ-041 Drive ser_in with 8'h3C frame at BIT_CLKS timing (+/-3% skew) -> rx_valid=1, rx_data=8'h3C, rx_frame_err=0; rx_ack clears rx_valid.
REQ-042 Two frames 8'h11, 8'h22 without rx_ack -> rx_data=8'h11, rx_overrun=1; rx_ack clears both flags.
REQ-043 Frame with stop bit 0, then 4-tick low glitch -> rx_frame_err=1, rx_valid=0, no byte from glitch; next good 8'h55 clears rx_frame_err.
REQ-044 reset_n asserted mid-TX frame and mid-RX frame -> outputs at REQ-037 values in the same cycle; loopback of 8'h7E after release received correctly.
